capture_ctrl_mc: RTL

Parametrised, multi-channel capture controller for the DSO sample RAM. It decimates the ADC sample stream and fills a circular buffer with a programmable pre/post-trigger split. It accepts a trigger from a selectable channel and reports trace end and trigger addresses to the readout/UART command logic. Beyond the single-channel generation, it adds parametrised depth and channel count, single-shot and auto-roll timeout modes, abort, and trigger-address capture.

---
 rtl/capture_pkg.sv | 18 +
 rtl/smpl_decimator.sv | 36 +++
 rtl/capture_ctrl_mc.sv | 227 ++++++++++++++++++++++
 3 files changed

// File: rtl/capture_pkg.sv
// Shared types for the DSO capture controller: capture modes and FSM states.
package capture_pkg;

    typedef enum logic [1:0] {
        OFF    = 2'd0,
        NORM   = 2'd1,
        AUTO   = 2'd2,
        SINGLE = 2'd3
    } mode_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PRE   = 2'd1,
        ARMED = 2'd2,
        POST  = 2'd3
    } state_t;

endpackage

// File: rtl/smpl_decimator.sv
// Sample decimator: keeps 1 of every 2^decimator valid ADC samples.
// The keep strobe is combinational in the cycle of the kept smpl_vld so the
// controller can register the RAM write on the following edge.
module smpl_decimator #(
    parameter int DEC_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             smpl_vld,
    input  logic [DEC_W-1:0] decimator,
    output logic             keep
);

    logic [15:0] r_cnt;
    logic [15:0] w_limit;

    assign w_limit = (16'd1 << decimator) - 16'd1;
    assign keep    = smpl_vld && (r_cnt == w_limit);

    // Decimation counter: clears on capture start or on a kept sample.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= 16'd0;
        end else if (clr) begin
            r_cnt <= 16'd0;
        end else if (keep) begin
            r_cnt <= 16'd0;
        end else if (smpl_vld) begin
            r_cnt <= r_cnt + 16'd1;
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/capture_ctrl_mc.sv
// Multi-channel capture controller: decimates the sample stream, fills a
// circular RAM with a programmable pre/post-trigger split and reports the
// trigger and trace-end addresses to the readout logic.
module capture_ctrl_mc
    import capture_pkg::*;
#(
    parameter int ADDR_W = 9,
    parameter int NUM_CH = 3,
    parameter int DEC_W  = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      smpl_vld,
    input  mode_t                     mode,
    input  logic [$clog2(NUM_CH)-1:0] trig_sel,
    input  logic [NUM_CH-1:0]         triggered,
    input  logic [ADDR_W-1:0]         trig_pos,
    input  logic [DEC_W-1:0]          decimator,
    input  logic                      clr_capture_done,
    input  logic                      abort,
    output logic                      we,
    output logic [ADDR_W-1:0]         waddr,
    output logic [ADDR_W-1:0]         trace_end,
    output logic [ADDR_W-1:0]         trig_addr,
    output logic                      capture_done,
    output logic                      armed,
    output logic                      busy
);

    localparam int SEL_W = $clog2(NUM_CH);
    // Kept-sample count that arms the AUTO-mode forced trigger (DEPTH).
    localparam logic [ADDR_W:0] DEPTH_CNT = {1'b1, {ADDR_W{1'b0}}};

    state_t              r_state,     w_state_nxt;
    mode_t               r_mode_cap,  w_mode_cap_nxt;
    logic [ADDR_W-1:0]   r_ptr,       w_ptr_nxt;
    logic [ADDR_W-1:0]   r_waddr,     w_waddr_nxt;
    logic [ADDR_W-1:0]   r_trace_end, w_trace_end_nxt;
    logic [ADDR_W-1:0]   r_trig_addr, w_trig_addr_nxt;
    logic [ADDR_W:0]     r_cnt,       w_cnt_nxt;
    logic                r_we,        w_we_nxt;
    logic                r_done,      w_done_nxt;
    logic                r_armed,     w_armed_nxt;
    logic                r_busy,      w_busy_nxt;
    logic                r_hold,      w_hold_nxt;
    logic                r_trig_prev, w_trig_prev_nxt;

    logic                w_keep;
    logic                w_start;
    logic                w_cancel;
    logic                w_write;
    logic                w_complete;
    logic                w_trig_lvl;
    logic                w_rise;
    logic                w_fire;
    logic [SEL_W-1:0]    w_sel;
    logic [ADDR_W-1:0]   w_pre_n;
    logic [ADDR_W:0]     w_cnt_inc;

    smpl_decimator #(
        .DEC_W (DEC_W)
    ) u_dec (
        .clk       (clk),
        .rst       (rst),
        .clr       (w_start),
        .smpl_vld  (smpl_vld),
        .decimator (decimator),
        .keep      (w_keep)
    );

    // Out-of-range channel selects fall back to channel 0.
    assign w_sel      = (32'(trig_sel) < NUM_CH) ? trig_sel : {SEL_W{1'b0}};
    assign w_trig_lvl = triggered[w_sel];
    assign w_rise     = w_trig_lvl && !r_trig_prev;
    // DEPTH-1-trig_pos reduces to the bitwise complement at ADDR_W bits.
    assign w_pre_n    = ~trig_pos;
    assign w_cnt_inc  = r_cnt + {{ADDR_W{1'b0}}, 1'b1};
    assign w_start    = (r_state == IDLE) && (mode != OFF) && !r_done && !r_hold;
    assign w_cancel   = (r_state != IDLE) && (abort || (mode != r_mode_cap));
    assign w_write    = w_keep && (r_state != IDLE) && !w_cancel;
    assign w_fire     = w_rise || ((r_mode_cap == AUTO) && (r_cnt == DEPTH_CNT));

    // Next-state and next-output computation for the capture FSM.
    always_comb begin
        w_state_nxt     = r_state;
        w_mode_cap_nxt  = r_mode_cap;
        w_cnt_nxt       = r_cnt;
        w_trace_end_nxt = r_trace_end;
        w_trig_addr_nxt = r_trig_addr;
        w_armed_nxt     = r_armed;
        w_complete      = 1'b0;
        w_we_nxt        = w_write;
        w_waddr_nxt     = w_write ? r_ptr : r_waddr;
        w_ptr_nxt       = w_write ? (r_ptr + {{(ADDR_W-1){1'b0}}, 1'b1}) : r_ptr;
        w_done_nxt      = clr_capture_done ? 1'b0 : r_done;
        w_hold_nxt      = (mode == OFF) ? 1'b0 : r_hold;
        // Outside ARMED the level is followed every cycle, so a level that is
        // already high when arming never looks like a rising edge.
        w_trig_prev_nxt = ((r_state == ARMED) && !w_keep) ? r_trig_prev : w_trig_lvl;

        case (r_state)
            IDLE: begin
                if (w_start) begin
                    w_ptr_nxt      = {ADDR_W{1'b0}};
                    w_cnt_nxt      = {(ADDR_W+1){1'b0}};
                    w_mode_cap_nxt = mode;
                    if (w_pre_n == {ADDR_W{1'b0}}) begin
                        w_state_nxt = ARMED;
                        w_armed_nxt = 1'b1;
                    end else begin
                        w_state_nxt = PRE;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            PRE: begin
                if (w_write) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == {1'b0, w_pre_n}) begin
                        w_state_nxt = ARMED;
                        w_armed_nxt = 1'b1;
                        w_cnt_nxt   = {(ADDR_W+1){1'b0}};
                    end else begin
                        w_state_nxt = PRE;
                    end
                end else begin
                    w_state_nxt = PRE;
                end
            end
            ARMED: begin
                if (w_write && w_fire) begin
                    w_trig_addr_nxt = r_ptr;
                    w_cnt_nxt       = {(ADDR_W+1){1'b0}};
                    if (trig_pos == {ADDR_W{1'b0}}) begin
                        w_complete = 1'b1;
                    end else begin
                        w_state_nxt = POST;
                    end
                end else if (w_write) begin
                    w_cnt_nxt = w_cnt_inc;
                end else begin
                    w_state_nxt = ARMED;
                end
            end
            POST: begin
                if (w_write) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_cnt_inc == {1'b0, trig_pos}) begin
                        w_complete = 1'b1;
                    end else begin
                        w_state_nxt = POST;
                    end
                end else begin
                    w_state_nxt = POST;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_armed_nxt = 1'b0;
            end
        endcase

        // Completion overrides a same-cycle clr_capture_done.
        if (w_complete) begin
            w_trace_end_nxt = r_ptr;
            w_done_nxt      = 1'b1;
            w_armed_nxt     = 1'b0;
            w_state_nxt     = IDLE;
            w_hold_nxt      = (r_mode_cap == SINGLE) ? 1'b1 : w_hold_nxt;
        end else begin
            w_trace_end_nxt = w_trace_end_nxt;
        end

        // Abort or mode change drops the capture without touching results.
        if (w_cancel) begin
            w_state_nxt = IDLE;
            w_armed_nxt = 1'b0;
        end else begin
            w_armed_nxt = w_armed_nxt;
        end

        w_busy_nxt = (w_state_nxt != IDLE);
    end

    // State and registered-output update with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_mode_cap  <= OFF;
            r_ptr       <= {ADDR_W{1'b0}};
            r_waddr     <= {ADDR_W{1'b0}};
            r_trace_end <= {ADDR_W{1'b0}};
            r_trig_addr <= {ADDR_W{1'b0}};
            r_cnt       <= {(ADDR_W+1){1'b0}};
            r_we        <= 1'b0;
            r_done      <= 1'b0;
            r_armed     <= 1'b0;
            r_busy      <= 1'b0;
            r_hold      <= 1'b0;
            r_trig_prev <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_mode_cap  <= w_mode_cap_nxt;
            r_ptr       <= w_ptr_nxt;
            r_waddr     <= w_waddr_nxt;
            r_trace_end <= w_trace_end_nxt;
            r_trig_addr <= w_trig_addr_nxt;
            r_cnt       <= w_cnt_nxt;
            r_we        <= w_we_nxt;
            r_done      <= w_done_nxt;
            r_armed     <= w_armed_nxt;
            r_busy      <= w_busy_nxt;
            r_hold      <= w_hold_nxt;
            r_trig_prev <= w_trig_prev_nxt;
        end
    end

    assign we           = r_we;
    assign waddr        = r_waddr;
    assign trace_end    = r_trace_end;
    assign trig_addr    = r_trig_addr;
    assign capture_done = r_done;
    assign armed        = r_armed;
    assign busy         = r_busy;

endmodule
